npu_mem_port_master: RTL and testbench
======================================

Name: npu_mem_port_master

Overview:
- Initiator for the NPU's external memory port (addr/wdata/we/ce in, rdata/ready out). That port is a responder, and this block is the requester that drives it.
- Accepts a burst command (direction, base word address, length) from a host-side controller.
- Write bursts take data from an AXI-stream slave and write it to consecutive addresses.
- Read bursts fetch consecutive words and return them on an AXI-stream master with tlast.
- A stalled responder is detected by a timeout and the burst is aborted.

Parameters:
- DATA_WIDTH, 32, memory and stream data width
- ADDR_WIDTH, 32, memory word-address width
- LEN_WIDTH, 16, burst length field width (words)
- TIMEOUT_CYCLES, 1024, consecutive ce-without-ready cycles before abort (≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  ADDR_WIDTH  base word address
- cmd_len  in  LEN_WIDTH  number of words
- s_axis_tdata  in  DATA_WIDTH  write data
- s_axis_tvalid  in  1  write data valid
- s_axis_tready  out  1  write data accepted
- m_axis_tdata  out  DATA_WIDTH  read data
- m_axis_tvalid  out  1  read data valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  final beat of read burst
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_we  out  1  write enable
- mem_ce  out  1  access request
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ce&&mem_ready&&!mem_we
- mem_ready  in  1  responder completes access this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at burst end (normal or aborted)
- error  out  1  sticky timeout flag, cleared on next command acceptance

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, hold and output registers empty. Reset mid-burst drops mem_ce immediately and abandons the burst.
- Memory handshake: a transfer occurs on a cycle with mem_ce&&mem_ready. While mem_ce=1 and mem_ready=0, mem_addr, mem_we and mem_wdata are held stable. Address increments by 1 per transfer, modulo 2^ADDR_WIDTH (wraps silently).
- IDLE:
  - cmd_ready=1.
  - On accept: latch addr, len and direction; clear error.
  - len=0 → DONE.
  - Otherwise, cmd_write=1 → WRITE and cmd_write=0 → READ.
- WRITE:
  - One-word hold register.
  - s_axis_tready = (words_accepted < len) && (!hold_valid || mem_transfer).
  - A stream beat loads hold. mem_ce = hold_valid and mem_we = 1, so the first memory write occurs no earlier than the cycle after the first beat.
  - Full throughput: 1 word/cycle when mem_ready and tvalid are held high.
  - After the len-th memory transfer → DONE.
- READ:
  - mem_we = 0.
  - mem_ce = (reads_issued < len) && (!m_axis_tvalid || m_axis_tready).
  - On transfer, mem_rdata is loaded into the output register: m_axis_tvalid=1 next cycle, and m_axis_tlast=1 if it is the len-th word.
  - After the last transfer → DRAIN.
- DRAIN: wait until m_axis_tvalid&&m_axis_tready with tlast, then → DONE.
- DONE: done=1 for exactly one cycle → IDLE. cmd_ready is 0 in this cycle.
- Timeout:
  - The counter increments each cycle mem_ce&&!mem_ready and resets on any transfer or when mem_ce=0.
  - When it reaches TIMEOUT_CYCLES, the abort applies next cycle:
    - mem_ce=0 and error=1;
    - hold and output registers cleared (m_axis_tvalid drops even if unaccepted, so no tlast is issued);
    - s_axis_tready=0;
    - → DONE.
- Stream data sent beyond len is never accepted; s_axis_tready stays 0 once len words have been taken.

Test Plan:
- Write len=4 at addr 0x100, stream 0xA0..0xA3 back-to-back, mem_ready=1 → mem writes 0x100..0x103 with matching data on consecutive cycles, done pulse, error=0.
- Read len=3 at 0x200, mem_ready=1, m_axis_tready toggling 1,0,1,1 → beats delivered in order, tlast only on the third, mem_ce held off while the output is full, no beat lost or duplicated.
- mem_ready low for 5 cycles mid-write → mem_addr and mem_wdata stable throughout, s_axis_tready=0 while hold is full, burst completes correctly.
- Read with mem_ready stuck 0, TIMEOUT_CYCLES=8 → mem_ce drops after 8 stall cycles, error=1, done pulse, m_axis_tvalid=0; next accepted command clears error.
- cmd_len=0 → done one cycle after acceptance, no mem_ce, no stream activity. Read len=2 at addr 0xFFFFFFFF → addresses 0xFFFFFFFF then 0x00000000.
- Assert rst_n=0 mid-read-burst → all outputs 0 asynchronously; after release, a new write burst len=1 completes normally.

Source files
------------

// File: rtl/npu_mem_port_master.sv
// rtl/npu_mem_port_master.sv - burst requester for the NPU external memory port
module npu_mem_port_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_ce,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  accept_cnt;
    logic [LEN_WIDTH-1:0]  xfer_cnt;
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  out_valid;
    logic                  out_last;
    logic [DATA_WIDTH-1:0] out_data;
    logic [TW-1:0]         to_cnt;
    logic                  error_q;

    logic accept, mem_xfer, stall, timeout_hit, last_xfer, s_beat, m_beat;

    assign cmd_ready     = rst_n && (state == IDLE);
    assign accept        = cmd_valid && cmd_ready;
    assign mem_we        = (state == WRITE);
    assign mem_addr      = addr_q;
    assign mem_wdata     = hold_data;
    assign m_axis_tdata  = out_data;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_valid && out_last;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign error         = error_q;

    always_comb begin
        mem_ce = 1'b0;
        if (state == WRITE)
            mem_ce = hold_valid;
        else if (state == READ)
            mem_ce = (xfer_cnt < len_q) && (!out_valid || m_axis_tready);
    end

    assign mem_xfer    = mem_ce && mem_ready;
    assign stall       = mem_ce && !mem_ready;
    assign timeout_hit = stall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign last_xfer   = mem_xfer && (xfer_cnt == len_q - LEN_WIDTH'(1));
    // The hold register may refill in the same cycle its word is written out.
    assign s_axis_tready = (state == WRITE) && (accept_cnt < len_q) &&
                           (!hold_valid || mem_xfer);
    assign s_beat = s_axis_tvalid && s_axis_tready;
    assign m_beat = out_valid && m_axis_tready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_len == '0)
                        state_nx = DONE;
                    else
                        state_nx = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (timeout_hit || last_xfer)
                    state_nx = DONE;
            end
            READ: begin
                if (timeout_hit)
                    state_nx = DONE;
                else if (last_xfer)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (m_beat && out_last)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            len_q      <= '0;
            accept_cnt <= '0;
            xfer_cnt   <= '0;
            error_q    <= 1'b0;
            to_cnt     <= '0;
        end else begin
            if (accept) begin
                addr_q     <= cmd_addr;
                len_q      <= cmd_len;
                accept_cnt <= '0;
                xfer_cnt   <= '0;
                error_q    <= 1'b0;
            end else begin
                if (mem_xfer) begin
                    addr_q   <= addr_q + ADDR_WIDTH'(1);
                    xfer_cnt <= xfer_cnt + LEN_WIDTH'(1);
                end
                if (s_beat)
                    accept_cnt <= accept_cnt + LEN_WIDTH'(1);
                if (timeout_hit)
                    error_q <= 1'b1;
            end
            // Counts consecutive stalled requests; cleared by any progress or idle ce.
            if (stall && !timeout_hit)
                to_cnt <= to_cnt + TW'(1);
            else
                to_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (timeout_hit) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (s_beat) begin
            hold_valid <= 1'b1;
            hold_data  <= s_axis_tdata;
        end else if (mem_xfer && mem_we) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (timeout_hit) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (mem_xfer && !mem_we) begin
            out_valid <= 1'b1;
            out_last  <= (xfer_cnt == len_q - LEN_WIDTH'(1));
            out_data  <= mem_rdata;
        end else if (m_beat) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_npu_mem_port_master.sv
// tb/tb_npu_mem_port_master.sv - self-checking bench for npu_mem_port_master
module tb_npu_mem_port_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we, mem_ce, mem_ready;
    logic          busy, done, error;

    always #5 clk = ~clk;

    npu_mem_port_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ce(mem_ce),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .done(done), .error(error)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_waddr[$], exp_wdata[$], exp_raddr[$], exp_rdata[$];
    bit          exp_rlast[$];
    logic [31:0] src[$];
    bit          rdy_script[$], trdy_script[$];
    int          rdy_prob, trdy_prob, tv_prob;

    int          cyc_n = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0, ce_cycles = 0;
    int          stall_run = 0, lat;
    bit          cmd_pending = 0, prev_stall = 0, prev_we = 0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;

    // Responder read data is a fixed hash of the word address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00005A5A;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        cmd_valid = cmd_pending;
        if (rdy_script.size() > 0)    mem_ready = rdy_script.pop_front();
        else if (stall_run >= 4)      mem_ready = 1'b1;
        else                          mem_ready = ($urandom_range(99) < rdy_prob);
        if (trdy_script.size() > 0)   m_axis_tready = trdy_script.pop_front();
        else                          m_axis_tready = ($urandom_range(99) < trdy_prob);
        s_axis_tvalid = (src.size() > 0) && ($urandom_range(99) < tv_prob);
        s_axis_tdata  = (src.size() > 0) ? src[0] : $urandom;
        mem_rdata     = mem_fn(mem_addr);
        #1;
        if (cmd_valid && cmd_ready) begin
            cmd_pending = 0;
            acc_cyc = cyc_n;
        end
        if (mem_ce) ce_cycles++;
        if (prev_stall && mem_ce) begin
            chk("stall_addr_stable", mem_addr, prev_addr);
            chk("stall_we_stable", mem_we, prev_we);
            if (mem_we) chk("stall_wdata_stable", mem_wdata, prev_wdata);
        end
        if (mem_ce && mem_we && !mem_ready) chk("s_tready_hold_full", s_axis_tready, 0);
        if (m_axis_tvalid && !m_axis_tready) chk("ce_backpressure", mem_ce, 0);
        if (mem_ce && mem_ready) begin
            if (mem_we) begin
                if (exp_waddr.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    chk("write_addr", mem_addr, exp_waddr.pop_front());
                    chk("write_data", mem_wdata, exp_wdata.pop_front());
                end
            end else begin
                if (exp_raddr.size() == 0) chk("unexpected_read", 1, 0);
                else chk("read_addr", mem_addr, exp_raddr.pop_front());
            end
        end
        if (s_axis_tvalid && s_axis_tready) void'(src.pop_front());
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_rdata.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
                chk("beat_data", m_axis_tdata, exp_rdata.pop_front());
                chk("beat_last", m_axis_tlast, exp_rlast.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
            chk("cmd_ready_in_done", cmd_ready, 0);
        end
        prev_stall = mem_ce && !mem_ready;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
        stall_run  = prev_stall ? stall_run + 1 : 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 500) begin
            cyc();
            n++;
        end
        chk("done_seen", done_cnt, 1);
    endtask

    task automatic run_burst(input bit wr, input logic [31:0] a, input int len,
                             input int extra, input bit seq, output int latency);
        logic [31:0] ai, d;
        for (int i = 0; i < len; i++) begin
            ai = a + 32'(i);
            if (wr) begin
                d = seq ? 32'hA0 + 32'(i) : $urandom;
                src.push_back(d);
                exp_waddr.push_back(ai);
                exp_wdata.push_back(d);
            end else begin
                exp_raddr.push_back(ai);
                exp_rdata.push_back(mem_fn(ai));
                exp_rlast.push_back(i == len - 1);
            end
        end
        for (int i = 0; i < extra; i++) src.push_back($urandom);
        done_cnt    = 0;
        ce_cycles   = 0;
        cmd_write   = wr;
        cmd_addr    = a;
        cmd_len     = LW'(len);
        cmd_pending = 1;
        wait_done();
        chk("error_clear", error, 0);
        latency = done_cyc - acc_cyc;
        cyc();
        chk("done_single_pulse", done, 0);
        chk("idle_after_done", busy, 0);
        chk("writes_all_seen", exp_waddr.size(), 0);
        chk("reads_all_issued", exp_raddr.size(), 0);
        chk("beats_all_seen", exp_rdata.size(), 0);
        chk("extra_beats_refused", src.size(), extra);
        src.delete();
    endtask

    initial begin
        rst_n = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        s_axis_tdata = '0; s_axis_tvalid = 0; m_axis_tready = 0;
        mem_rdata = '0; mem_ready = 0;
        rdy_prob = 100; trdy_prob = 100; tv_prob = 100;
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_mem_ce", mem_ce, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_m_valid", m_axis_tvalid, 0);
        chk("rst_busy_done_error", {busy, done, error}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Back-to-back write with two surplus stream beats.
        run_burst(1, 32'h100, 4, 2, 1, lat);
        chk("write_full_rate_latency", lat, 6);

        // Read with downstream backpressure.
        trdy_script = '{1, 1, 1, 0, 1, 1};
        run_burst(0, 32'h200, 3, 0, 0, lat);
        chk("read_backpressure_latency", lat, 6);

        // Write with a five-cycle responder stall.
        rdy_script = '{1, 1, 0, 0, 0, 0, 0};
        run_burst(1, 32'h180, 4, 0, 0, lat);
        chk("write_stall_latency", lat, 11);

        // Read against a dead responder.
        for (int i = 0; i < 20; i++) rdy_script.push_back(0);
        done_cnt = 0; ce_cycles = 0;
        cmd_write = 0; cmd_addr = 32'h300; cmd_len = 3; cmd_pending = 1;
        wait_done();
        chk("timeout_ce_cycles", ce_cycles, TO);
        chk("timeout_error", error, 1);
        chk("timeout_m_valid", m_axis_tvalid, 0);
        chk("timeout_ce_dropped", mem_ce, 0);
        rdy_script.delete();

        // Zero-length command also clears the sticky error.
        run_burst(0, 32'h10, 0, 0, 0, lat);
        chk("len0_latency", lat, 1);
        chk("len0_no_ce", ce_cycles, 0);

        run_burst(0, 32'hFFFF_FFFF, 2, 0, 0, lat);
        chk("wrap_read_latency", lat, 4);

        // Reset in the middle of a read burst.
        trdy_prob = 50;
        run_burst_start: begin
            for (int i = 0; i < 8; i++) begin
                exp_raddr.push_back(32'h400 + 32'(i));
                exp_rdata.push_back(mem_fn(32'h400 + 32'(i)));
                exp_rlast.push_back(i == 7);
            end
            cmd_write = 0; cmd_addr = 32'h400; cmd_len = 8; cmd_pending = 1;
            repeat (4) cyc();
            #2 rst_n = 0;
            #1;
            chk("midrst_mem_ce", mem_ce, 0);
            chk("midrst_busy", busy, 0);
            chk("midrst_m_valid", m_axis_tvalid, 0);
            chk("midrst_addr", mem_addr, 0);
            exp_raddr.delete(); exp_rdata.delete(); exp_rlast.delete();
            cmd_pending = 0; prev_stall = 0; stall_run = 0;
            @(negedge clk);
            rst_n = 1;
        end
        trdy_prob = 100;
        run_burst(1, 32'h500, 1, 0, 0, lat);
        chk("post_rst_write_latency", lat, 3);

        // Randomized bursts under random handshakes.
        rdy_prob = 75; trdy_prob = 70; tv_prob = 70;
        for (int k = 0; k < 16; k++) begin
            logic [31:0] ra;
            ra = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 + $urandom_range(7) : $urandom;
            run_burst($urandom_range(1), ra, $urandom_range(10), $urandom_range(2), 0, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
